game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_pkg.sv | 20 ++
 rtl/btn_edge_sync.sv | 32 +++
 rtl/game_state_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-state encodings and frame-counter type, also used by the text renderer.
package game_pkg;

    localparam int unsigned CntWidth = 8;

    typedef logic [CntWidth-1:0] cnt_t;

    typedef enum logic [1:0] {
        StTitle    = 2'b00,
        StRearm    = 2'b01,
        StGameover = 2'b10,
        StPlay     = 2'b11
    } game_state_e;

    // Count value seen on the tick that completes a span of `frames` ticks.
    function automatic cnt_t cnt_last(int unsigned frames);
        return cnt_t'(frames - 1);
    endfunction

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchronizer plus registered rising-edge detector for the start button.
// A level already high when reset is released never produces a pulse.
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic rise_pulse
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [2:0] warm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            warm       <= 3'b000;
            rise_pulse <= 1'b0;
        end else begin
            sync1      <= btn_in;
            sync2      <= sync1;
            prev       <= sync2;
            warm       <= {warm[1:0], 1'b1};
            // warm[2] marks prev as holding a real post-reset sample, not the reset zero.
            rise_pulse <= sync2 & ~prev & warm[2];
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: TITLE -> REARM -> PLAY -> (REARM | GAMEOVER) -> TITLE.
// Optional title-text blinking is enabled by defining GAME_TITLE_BLINK_EN.
module game_state_ctrl
    import game_pkg::*;
#(
    parameter int unsigned LIVES_INIT      = 3,
    parameter int unsigned REARM_FRAMES    = 120,
    parameter int unsigned GAMEOVER_FRAMES = 180,
    parameter int unsigned BLINK_FRAMES    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       ship_hit,
    output logic [1:0] state_set,
    output logic       text_en,
    output logic [2:0] lives,
    output logic       game_active,
    output logic       respawn
);

    game_state_e state;
    cnt_t        frame_cnt;
    logic        start_evt;

`ifdef GAME_TITLE_BLINK_EN
    cnt_t        blink_cnt;
`else
    logic        unused_blink_frames;
    assign unused_blink_frames = ^BLINK_FRAMES;
`endif

    btn_edge_sync u_btn_edge_sync (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (start_btn),
        .rise_pulse (start_evt)
    );

    assign state_set = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StTitle;
            frame_cnt   <= '0;
            lives       <= 3'd0;
            text_en     <= 1'b1;
            game_active <= 1'b0;
            respawn     <= 1'b0;
`ifdef GAME_TITLE_BLINK_EN
            blink_cnt   <= '0;
`endif
        end else begin
            respawn <= 1'b0;
            unique case (state)
                StTitle: begin
                    if (start_evt) begin
                        state     <= StRearm;
                        lives     <= 3'(LIVES_INIT);
                        frame_cnt <= '0;
                        text_en   <= 1'b1;
`ifdef GAME_TITLE_BLINK_EN
                        blink_cnt <= '0;
                    end else if (frame_tick) begin
                        if (blink_cnt == cnt_last(BLINK_FRAMES)) begin
                            blink_cnt <= '0;
                            text_en   <= ~text_en;
                        end else begin
                            blink_cnt <= blink_cnt + 1'b1;
                        end
`endif
                    end
                end

                StRearm: begin
                    if (frame_tick) begin
                        if (frame_cnt == cnt_last(REARM_FRAMES)) begin
                            state       <= StPlay;
                            frame_cnt   <= '0;
                            respawn     <= 1'b1;
                            game_active <= 1'b1;
                            text_en     <= 1'b0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                // Ticks are not counted in PLAY, so a coincident tick is simply dropped.
                StPlay: begin
                    if (ship_hit) begin
                        frame_cnt   <= '0;
                        game_active <= 1'b0;
                        text_en     <= 1'b1;
                        if (lives > 3'd1) begin
                            state <= StRearm;
                            lives <= lives - 3'd1;
                        end else begin
                            state <= StGameover;
                            lives <= 3'd0;
                        end
                    end
                end

                StGameover: begin
                    if (frame_tick) begin
                        if (frame_cnt == cnt_last(GAMEOVER_FRAMES)) begin
                            state     <= StTitle;
                            frame_cnt <= '0;
                            text_en   <= 1'b1;
`ifdef GAME_TITLE_BLINK_EN
                            blink_cnt <= '0;
`endif
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= StTitle;
                end
            endcase
        end
    end

endmodule
